// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-port synchronous data memory between two requesters:
//   port 0 (processor load/store path) and port 1 (loader / DMA master).
//   One access is outstanding at a time. Each access runs through a small
//   FSM (IDLE -> ACCESS [-> RDWAIT] -> IDLE). Read data is returned on a
//   shared rdata bus and qualified by a one-cycle per-port rvalid pulse.
//
// Parameters
//   AW        address width
//   DW        data width
//   PRIO_MODE 0 = round-robin (tie goes to the port not granted last),
//             1 = fixed priority (port 0 wins whenever it requests)
//
// Ports
//   Clock                    system clock, rising edge
//   Resetn                   asynchronous reset, ACTIVE HIGH despite the name
//   req0/we0/addr0/wdata0    port 0 request, held until gnt0
//   gnt0                     port 0 accepted this cycle (combinational)
//   rvalid0                  port 0 read data valid pulse
//   req1/we1/addr1/wdata1,
//   gnt1, rvalid1            same for port 1
//   rdata                    shared read data, held until the next read ends
//   mem_en/mem_we/mem_addr/
//   mem_wdata                memory-side access controls (registered)
//   mem_rdata                memory read data, valid the cycle after mem_en
//   busy                     FSM not in IDLE
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int AW        = 16,
    parameter int DW        = 16,
    parameter int PRIO_MODE = 0
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RDWAIT = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;

    logic          r_ptr;      // port preferred on a round-robin tie
    logic          r_owner;    // port that owns the access in flight
    logic          r_mem_en;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic [DW-1:0] r_rdata;
    logic          r_rvalid0;
    logic          r_rvalid1;

    logic          w_idle;
    logic          w_pick1;
    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_any_gnt;

    // ------------------------------------------------------------------
    // Arbitration. Port 1 wins when it is alone, or on a tie when the
    // round-robin pointer favours it. Fixed priority never lets it win a tie.
    // ------------------------------------------------------------------
    assign w_idle = (r_state == S_IDLE);

    always_comb begin
        w_pick1 = 1'b0;
        if (PRIO_MODE != 0) begin
            w_pick1 = req1 & ~req0;
        end else begin
            w_pick1 = req1 & (~req0 | r_ptr);
        end
    end

    // Grants are gated by reset too: the state is already IDLE while reset
    // is held, but requests must not see a grant during that time.
    assign w_gnt0    = w_idle & ~Resetn & req0 & ~w_pick1;
    assign w_gnt1    = w_idle & ~Resetn & w_pick1;
    assign w_any_gnt = w_gnt0 | w_gnt1;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or posedge Resetn) begin
        if (Resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state. In ACCESS, r_mem_we still holds the access type.
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_any_gnt) begin
                    w_next = S_ACCESS;
                end
            end
            S_ACCESS: begin
                w_next = r_mem_we ? S_IDLE : S_RDWAIT;
            end
            S_RDWAIT: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Memory-side controls, pointer and read return path.
    // Async reset clears mem_we/mem_en at once, aborting any access.
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or posedge Resetn) begin
        if (Resetn) begin
            r_ptr       <= 1'b0;
            r_owner     <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
            r_rvalid0   <= 1'b0;
            r_rvalid1   <= 1'b0;
        end else begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_gnt) begin
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= w_gnt1 ? we1    : we0;
                        r_mem_addr  <= w_gnt1 ? addr1  : addr0;
                        r_mem_wdata <= w_gnt1 ? wdata1 : wdata0;
                        r_owner     <= w_gnt1;
                        // next tie goes to the port that did not just win
                        r_ptr       <= ~w_gnt1;
                    end
                end
                S_ACCESS: begin
                    r_mem_en <= 1'b0;
                    r_mem_we <= 1'b0;
                end
                S_RDWAIT: begin
                    r_rdata <= mem_rdata;
                    if (r_owner) begin
                        r_rvalid1 <= 1'b1;
                    end else begin
                        r_rvalid0 <= 1'b1;
                    end
                end
                default: begin
                    r_mem_en <= 1'b0;
                    r_mem_we <= 1'b0;
                end
            endcase
        end
    end

    assign gnt0      = w_gnt0;
    assign gnt1      = w_gnt1;
    assign rvalid0   = r_rvalid0;
    assign rvalid1   = r_rvalid1;
    assign rdata     = r_rdata;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = ~w_idle;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        Clock = 1'b0;
    logic        Resetn;
    logic        req0, we0, req1, we1;
    logic [15:0] addr0, wdata0, addr1, wdata1;

    logic        rr_gnt0, rr_gnt1, rr_rvalid0, rr_rvalid1, rr_mem_en, rr_mem_we, rr_busy;
    logic [15:0] rr_rdata, rr_mem_addr, rr_mem_wdata, rr_mem_rdata;
    logic        fp_gnt0, fp_gnt1, fp_rvalid0, fp_rvalid1, fp_mem_en, fp_mem_we, fp_busy;
    logic [15:0] fp_rdata, fp_mem_addr, fp_mem_wdata, fp_mem_rdata;

    logic [15:0] mem_rr [256];
    logic [15:0] mem_fp [256];
    logic [15:0] shadow [256];
    logic        mem_init;

    int checks   = 0;
    int failures = 0;
    int gq[$];

    always #5 Clock = ~Clock;

    mem_arbiter #(.AW(16), .DW(16), .PRIO_MODE(0)) dut_rr (
        .Clock(Clock), .Resetn(Resetn),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(rr_gnt0), .rvalid0(rr_rvalid0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(rr_gnt1), .rvalid1(rr_rvalid1),
        .rdata(rr_rdata), .mem_en(rr_mem_en), .mem_we(rr_mem_we), .mem_addr(rr_mem_addr),
        .mem_wdata(rr_mem_wdata), .mem_rdata(rr_mem_rdata), .busy(rr_busy));

    mem_arbiter #(.AW(16), .DW(16), .PRIO_MODE(1)) dut_fp (
        .Clock(Clock), .Resetn(Resetn),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(fp_gnt0), .rvalid0(fp_rvalid0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(fp_gnt1), .rvalid1(fp_rvalid1),
        .rdata(fp_rdata), .mem_en(fp_mem_en), .mem_we(fp_mem_we), .mem_addr(fp_mem_addr),
        .mem_wdata(fp_mem_wdata), .mem_rdata(fp_mem_rdata), .busy(fp_busy));

    function automatic logic [15:0] init_val(input logic [7:0] a);
        return (a == 8'h10) ? 16'h1234 : {a, ~a};
    endfunction

    // Synchronous single-port memories, one per DUT.
    always @(posedge Clock) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) begin
                mem_rr[i] <= init_val(i[7:0]);
                mem_fp[i] <= init_val(i[7:0]);
            end
        end else begin
            if (rr_mem_en && rr_mem_we)  mem_rr[rr_mem_addr[7:0]] <= rr_mem_wdata;
            if (rr_mem_en && !rr_mem_we) rr_mem_rdata <= mem_rr[rr_mem_addr[7:0]];
            if (fp_mem_en && fp_mem_we)  mem_fp[fp_mem_addr[7:0]] <= fp_mem_wdata;
            if (fp_mem_en && !fp_mem_we) fp_mem_rdata <= mem_fp[fp_mem_addr[7:0]];
        end
    end

    task automatic do_reset();
        @(posedge Clock); #1;
        Resetn = 1'b1; req0 = 1'b0; req1 = 1'b0;
        @(posedge Clock); #1;
        Resetn = 1'b0;
    endtask

    task automatic test_reset();
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b0;
        #1;
        checks++; if (rr_gnt0 !== 1'b0) begin failures++; $display("FAIL reset_gnt0 got=%b exp=0", rr_gnt0); end
        checks++; if (rr_gnt1 !== 1'b0) begin failures++; $display("FAIL reset_gnt1 got=%b exp=0", rr_gnt1); end
        checks++; if (fp_gnt0 !== 1'b0) begin failures++; $display("FAIL reset_fp_gnt0 got=%b exp=0", fp_gnt0); end
        checks++; if (rr_mem_en !== 1'b0) begin failures++; $display("FAIL reset_mem_en got=%b exp=0", rr_mem_en); end
        checks++; if (rr_mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%b exp=0", rr_mem_we); end
        checks++; if (rr_mem_addr !== 16'h0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0", rr_mem_addr); end
        checks++; if (rr_mem_wdata !== 16'h0) begin failures++; $display("FAIL reset_mem_wdata got=%h exp=0", rr_mem_wdata); end
        checks++; if (rr_rdata !== 16'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rr_rdata); end
        checks++; if ({rr_rvalid0, rr_rvalid1} !== 2'b00) begin failures++; $display("FAIL reset_rvalid got=%b exp=00", {rr_rvalid0, rr_rvalid1}); end
        checks++; if (rr_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", rr_busy); end
        @(posedge Clock); #1;
        req0 = 1'b0; req1 = 1'b0; Resetn = 1'b0;
        @(negedge Clock);
        checks++; if ({rr_gnt0, rr_gnt1, rr_busy} !== 3'b000) begin failures++; $display("FAIL idle_no_req got=%b exp=000", {rr_gnt0, rr_gnt1, rr_busy}); end
    endtask

    task automatic test_write();
        @(posedge Clock); #1;
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0005; wdata0 = 16'hABCD;
        @(negedge Clock);
        checks++; if ({rr_gnt0, rr_gnt1} !== 2'b10) begin failures++; $display("FAIL wr_gnt got=%b exp=10", {rr_gnt0, rr_gnt1}); end
        shadow[8'h05] = 16'hABCD;
        @(posedge Clock); #1;
        req0 = 1'b0;
        @(negedge Clock);
        checks++; if ({rr_mem_en, rr_mem_we} !== 2'b11) begin failures++; $display("FAIL wr_en_we got=%b exp=11", {rr_mem_en, rr_mem_we}); end
        checks++; if (rr_mem_addr !== 16'h0005) begin failures++; $display("FAIL wr_addr got=%h exp=0005", rr_mem_addr); end
        checks++; if (rr_mem_wdata !== 16'hABCD) begin failures++; $display("FAIL wr_wdata got=%h exp=abcd", rr_mem_wdata); end
        checks++; if (rr_busy !== 1'b1) begin failures++; $display("FAIL wr_busy got=%b exp=1", rr_busy); end
        @(posedge Clock); #1;
        @(negedge Clock);
        checks++; if ({rr_busy, rr_mem_en, rr_mem_we} !== 3'b000) begin failures++; $display("FAIL wr_done got=%b exp=000", {rr_busy, rr_mem_en, rr_mem_we}); end
        checks++; if (mem_rr[8'h05] !== 16'hABCD) begin failures++; $display("FAIL wr_mem got=%h exp=abcd", mem_rr[8'h05]); end
    endtask

    task automatic test_read_p1();
        @(posedge Clock); #1;
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0010; wdata1 = 16'h0;
        @(negedge Clock);
        checks++; if ({rr_gnt0, rr_gnt1} !== 2'b01) begin failures++; $display("FAIL rd_gnt got=%b exp=01", {rr_gnt0, rr_gnt1}); end
        @(posedge Clock); #1;
        req1 = 1'b0;
        @(negedge Clock);
        checks++; if ({rr_mem_en, rr_mem_we} !== 2'b10) begin failures++; $display("FAIL rd_en_we got=%b exp=10", {rr_mem_en, rr_mem_we}); end
        checks++; if (rr_mem_addr !== 16'h0010) begin failures++; $display("FAIL rd_addr got=%h exp=0010", rr_mem_addr); end
        @(negedge Clock);
        checks++; if ({rr_busy, rr_rvalid1} !== 2'b10) begin failures++; $display("FAIL rd_wait got=%b exp=10", {rr_busy, rr_rvalid1}); end
        @(negedge Clock);
        checks++; if ({rr_rvalid0, rr_rvalid1} !== 2'b01) begin failures++; $display("FAIL rd_rvalid got=%b exp=01", {rr_rvalid0, rr_rvalid1}); end
        checks++; if (rr_rdata !== 16'h1234) begin failures++; $display("FAIL rd_rdata got=%h exp=1234", rr_rdata); end
        @(negedge Clock);
        checks++; if (rr_rvalid1 !== 1'b0) begin failures++; $display("FAIL rd_pulse got=%b exp=0", rr_rvalid1); end
        checks++; if (rr_rdata !== 16'h1234) begin failures++; $display("FAIL rd_hold got=%h exp=1234", rr_rdata); end
    endtask

    // Cycle-level reference: an access granted at cycle c blocks grants
    // until c+2 (write) or c+3 (read); a read returns shadow data at c+3.
    task automatic run_model(input int n, input bit hold);
        int          free_at = 0;
        int          ptr = 0;
        int          w;
        bit          act[2];
        bit          glast[2];
        bit          wq[2];
        logic [15:0] aq[2];
        logic [15:0] dq[2];
        int          due_q[$];
        int          port_q[$];
        logic [15:0] data_q[$];
        bit          ev0, ev1;
        logic [15:0] erd;
        for (int p = 0; p < 2; p++) begin
            act[p] = 0; glast[p] = 0; wq[p] = 0; aq[p] = '0; dq[p] = '0;
        end
        do_reset();
        gq.delete();
        for (int c = 0; c < n; c++) begin
            @(posedge Clock); #1;
            for (int p = 0; p < 2; p++) begin
                if (!act[p] || glast[p]) begin
                    if (hold || $urandom_range(1, 0) == 1) begin
                        act[p] = 1;
                        wq[p]  = hold ? 1'b0 : 1'($urandom_range(1, 0));
                        aq[p]  = {8'h00, 8'($urandom)};
                        dq[p]  = 16'($urandom);
                    end else begin
                        act[p] = 0;
                    end
                end else if (!hold && $urandom_range(7, 0) == 0) begin
                    act[p] = 0;
                end
                glast[p] = 0;
            end
            req0 = act[0]; we0 = wq[0]; addr0 = aq[0]; wdata0 = dq[0];
            req1 = act[1]; we1 = wq[1]; addr1 = aq[1]; wdata1 = dq[1];
            @(negedge Clock);
            w = -1;
            if (c >= free_at) begin
                if (act[0] && act[1]) w = ptr;
                else if (act[0])      w = 0;
                else if (act[1])      w = 1;
            end
            checks++; if ({rr_gnt0, rr_gnt1} !== {w == 0, w == 1}) begin failures++; $display("FAIL m_gnt c=%0d got=%b exp=%b", c, {rr_gnt0, rr_gnt1}, {w == 0, w == 1}); end
            checks++; if (rr_busy !== (c < free_at)) begin failures++; $display("FAIL m_busy c=%0d got=%b exp=%b", c, rr_busy, c < free_at); end
            ev0 = 0; ev1 = 0; erd = '0;
            if (due_q.size() > 0 && due_q[0] == c) begin
                ev0 = (port_q[0] == 0); ev1 = (port_q[0] == 1); erd = data_q[0];
                void'(due_q.pop_front()); void'(port_q.pop_front()); void'(data_q.pop_front());
            end
            checks++; if ({rr_rvalid0, rr_rvalid1} !== {ev0, ev1}) begin failures++; $display("FAIL m_rvalid c=%0d got=%b exp=%b", c, {rr_rvalid0, rr_rvalid1}, {ev0, ev1}); end
            if (ev0 || ev1) begin
                checks++; if (rr_rdata !== erd) begin failures++; $display("FAIL m_rdata c=%0d got=%h exp=%h", c, rr_rdata, erd); end
            end
            if (w >= 0) begin
                gq.push_back(w);
                glast[w] = 1;
                ptr = 1 - w;
                if (wq[w]) begin
                    shadow[aq[w][7:0]] = dq[w];
                    free_at = c + 2;
                end else begin
                    due_q.push_back(c + 3); port_q.push_back(w); data_q.push_back(shadow[aq[w][7:0]]);
                    free_at = c + 3;
                end
            end
        end
        @(posedge Clock); #1;
        req0 = 1'b0; req1 = 1'b0;
        repeat (4) @(posedge Clock);
    endtask

    task automatic test_round_robin();
        run_model(24, 1'b1);
        checks++; if (gq.size() < 6) begin failures++; $display("FAIL rr_count got=%0d exp>=6", gq.size()); end
        for (int i = 0; i < gq.size(); i++) begin
            checks++; if (gq[i] != i % 2) begin failures++; $display("FAIL rr_order i=%0d got=%0d exp=%0d", i, gq[i], i % 2); end
        end
    endtask

    task automatic test_fixed_prio();
        int g1 = 0;
        int first0 = -1;
        bit found = 0;
        int k1 = 0;
        do_reset();
        @(posedge Clock); #1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0040;
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0041;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) begin @(posedge Clock); #1; end
            @(negedge Clock);
            if (fp_gnt1) g1++;
            if (fp_gnt0 && first0 < 0) first0 = c;
        end
        checks++; if (g1 != 0) begin failures++; $display("FAIL fp_starve got=%0d exp=0", g1); end
        checks++; if (first0 != 0) begin failures++; $display("FAIL fp_first got=%0d exp=0", first0); end
        for (int k = 0; k < 6 && !found; k++) begin
            @(posedge Clock); #1;
            @(negedge Clock);
            if (fp_gnt0) found = 1;
        end
        checks++; if (!found) begin failures++; $display("FAIL fp_wait_gnt0 got=timeout exp=gnt0"); end
        for (int k = 1; k <= 6 && k1 == 0; k++) begin
            @(posedge Clock); #1;
            if (k == 1) req0 = 1'b0;
            @(negedge Clock);
            if (fp_gnt1) k1 = k;
        end
        checks++; if (k1 != 3) begin failures++; $display("FAIL fp_gnt1_after_drop got=%0d exp=3", k1); end
        @(posedge Clock); #1;
        req1 = 1'b0;
        repeat (4) @(posedge Clock);
    endtask

    task automatic test_back_to_back();
        int last;
        int cnt;
        bit glast;
        do_reset();
        for (int mode = 1; mode >= 0; mode--) begin
            last = -1; cnt = 0; glast = 1;
            for (int c = 0; c < 12; c++) begin
                @(posedge Clock); #1;
                if (glast) begin
                    req0 = 1'b1; we0 = mode[0]; addr0 = {8'h00, 8'($urandom)}; wdata0 = 16'($urandom);
                    glast = 0;
                end
                @(negedge Clock);
                checks++; if ((rr_gnt0 & rr_busy) !== 1'b0) begin failures++; $display("FAIL b2b_gnt_busy c=%0d got=%b exp=0", c, rr_gnt0 & rr_busy); end
                if (rr_gnt0) begin
                    if (mode == 1) shadow[addr0[7:0]] = wdata0;
                    if (last >= 0) begin
                        checks++; if (c - last != 3 - mode) begin failures++; $display("FAIL b2b_interval we=%0d got=%0d exp=%0d", mode, c - last, 3 - mode); end
                    end
                    last = c; cnt++; glast = 1;
                end
            end
            checks++; if (cnt != ((mode == 1) ? 6 : 4)) begin failures++; $display("FAIL b2b_count we=%0d got=%0d exp=%0d", mode, cnt, (mode == 1) ? 6 : 4); end
            @(posedge Clock); #1;
            req0 = 1'b0;
            repeat (4) @(posedge Clock);
        end
    endtask

    task automatic test_reset_midop();
        // abort a port 0 read in RDWAIT
        do_reset();
        @(posedge Clock); #1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0020;
        @(negedge Clock);
        checks++; if (rr_gnt0 !== 1'b1) begin failures++; $display("FAIL mid_gnt0 got=%b exp=1", rr_gnt0); end
        @(posedge Clock); #1;
        req0 = 1'b0;
        @(posedge Clock); #1;
        checks++; if (rr_busy !== 1'b1) begin failures++; $display("FAIL mid_rdwait_busy got=%b exp=1", rr_busy); end
        #1;
        Resetn = 1'b1; req0 = 1'b1; req1 = 1'b1; we1 = 1'b0;
        #1;
        checks++; if ({rr_mem_en, rr_mem_we, rr_busy} !== 3'b000) begin failures++; $display("FAIL mid_abort got=%b exp=000", {rr_mem_en, rr_mem_we, rr_busy}); end
        checks++; if ({rr_gnt0, rr_gnt1} !== 2'b00) begin failures++; $display("FAIL mid_gnt_in_reset got=%b exp=00", {rr_gnt0, rr_gnt1}); end
        @(posedge Clock); #1;
        req0 = 1'b0; req1 = 1'b0; Resetn = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge Clock);
            checks++; if (rr_rvalid0 !== 1'b0) begin failures++; $display("FAIL mid_no_rvalid c=%0d got=%b exp=0", c, rr_rvalid0); end
        end
        @(posedge Clock); #1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0021;
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0022;
        @(negedge Clock);
        checks++; if ({rr_gnt0, rr_gnt1} !== 2'b10) begin failures++; $display("FAIL mid_tie_after_reset got=%b exp=10", {rr_gnt0, rr_gnt1}); end
        @(posedge Clock); #1;
        req0 = 1'b0; req1 = 1'b0;
        repeat (4) @(posedge Clock);
        // abort a port 0 write in ACCESS: mem_we must drop before the edge
        do_reset();
        @(posedge Clock); #1;
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0030; wdata0 = 16'h5555;
        @(posedge Clock); #1;
        req0 = 1'b0;
        #2;
        checks++; if (rr_mem_we !== 1'b1) begin failures++; $display("FAIL midw_we_before got=%b exp=1", rr_mem_we); end
        Resetn = 1'b1;
        #1;
        checks++; if ({rr_mem_en, rr_mem_we} !== 2'b00) begin failures++; $display("FAIL midw_we_async got=%b exp=00", {rr_mem_en, rr_mem_we}); end
        @(posedge Clock); #1;
        Resetn = 1'b0;
        @(negedge Clock);
        checks++; if (mem_rr[8'h30] !== shadow[8'h30]) begin failures++; $display("FAIL midw_no_write got=%h exp=%h", mem_rr[8'h30], shadow[8'h30]); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Resetn = 1'b1; mem_init = 1'b1;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        for (int i = 0; i < 256; i++) shadow[i] = init_val(i[7:0]);
        repeat (2) @(posedge Clock);
        #1 mem_init = 1'b0;
        test_reset();
        test_write();
        test_read_p1();
        test_round_robin();
        test_fixed_prio();
        test_back_to_back();
        test_reset_midop();
        run_model(300, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates a single-port synchronous 16-bit data memory between two requesters.
  - Port 0: the processor load/store path (addrM/doutM/wM side).
  - Port 1: a secondary master, e.g. program loader or I/O DMA.
- Sequences each access through a small FSM, drives the memory-side enable, write and address, and returns read data with a per-port valid pulse.
- Only one access is outstanding at any time.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- PRIO_MODE, 0: 0 = round-robin, 1 = fixed priority (port 0 always wins).

Ports:
- Clock  in  1  system clock, rising edge.
- Resetn  in  1  asynchronous, active-high reset.
- req0  in  1  port 0 access request; held until gnt0.
- we0  in  1  port 0 write (1) / read (0); stable while req0 is high.
- addr0  in  AW  port 0 address.
- wdata0  in  DW  port 0 write data.
- gnt0  out  1  port 0 request accepted this cycle.
- rvalid0  out  1  port 0 read data valid, one-cycle pulse.
- req1, we1, addr1, wdata1, gnt1, rvalid1: same as port 0, for port 1.
- rdata  out  DW  read data shared by both ports; qualify with rvalid0/rvalid1.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid the cycle after a read with mem_en=1.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (Resetn=1, asynchronous): state=IDLE, round-robin pointer=port 0. Outputs under reset:
  - mem_en, mem_we = 0; mem_addr, mem_wdata, rdata = 0.
  - rvalid0, rvalid1 = 0; busy = 0.
  - gnt0, gnt1 forced to 0 while Resetn=1, even if requests are high.
- States: IDLE, ACCESS, RDWAIT.
- IDLE:
  - gnt is combinational and goes to the winner among active reqs.
  - On the clock edge with a grant, the winner's we/addr/wdata are captured into mem_we/mem_addr/mem_wdata, mem_en<=1, and the FSM moves to ACCESS.
  - No request: remain in IDLE.
- Arbitration:
  - PRIO_MODE=1: port 0 wins whenever req0=1.
  - PRIO_MODE=0: the port not granted last wins a tie; the pointer updates on every grant.
  - A lone request always wins.
- ACCESS, one cycle:
  - Memory sees the access.
  - Write: next state IDLE; mem_en, mem_we <= 0.
  - Read: next state RDWAIT; mem_en <= 0.
- RDWAIT, one cycle: rdata <= mem_rdata; rvalid of the owning port <= 1 at the edge; next state IDLE.
- rvalid is a one-cycle pulse, high in the first IDLE cycle after RDWAIT.
- rdata holds its value until the next read completes.
- Latency, grant at cycle T:
  - Write: memory written at the end of T+1; next grant possible at T+2.
  - Read: mem_en at T+1, mem_rdata at T+2, rdata/rvalid visible at T+3; next grant possible at T+3, the same cycle as rvalid.
- Handshake:
  - A requester must deassert req, or present a new request, in the cycle after gnt.
  - A req still high in IDLE is a new request.
  - Grants never occur outside IDLE; requests simply wait.
- Reset mid-operation aborts the access:
  - No rvalid pulse is produced.
  - mem_we drops immediately, asynchronously.
  - The round-robin pointer returns to port 0.
- A req that drops before being granted is forgotten; there is no latching of ungranted requests.

Test Plan:
- Port 0 write: req0=1, we0=1, addr0=0x0005, wdata0=0xABCD -> gnt0 same cycle; next cycle mem_en=1, mem_we=1, mem_addr=0x0005, mem_wdata=0xABCD; busy for 1 cycle.
- Port 1 read: memory model holds 0x1234 at 0x0010; req1 read 0x0010 -> gnt1 at T; mem_en=1, mem_we=0 at T+1; rdata=0x1234 and rvalid1=1 at T+3 for one cycle; rvalid0 stays 0.
- Round-robin (PRIO_MODE=0): req0 and req1 held high, new read each grant -> grants alternate 0,1,0,1, starting with port 0 after reset; each rvalid goes to the matching port.
- Fixed priority (PRIO_MODE=1): req0 and req1 continuously high -> gnt1 never asserts; drop req0 -> gnt1 at the next IDLE cycle.
- Reset during RDWAIT of a port 0 read -> mem_en=mem_we=0 and busy=0 immediately; no rvalid0 after release; first post-reset tie grants port 0.
- Back-to-back writes from port 0 -> gnt0 every 2 cycles; reads every 3 cycles; gnt is never asserted while busy=1.
